// File: rtl/phase_shift_checker.sv
//----------------------------------------------------------------------------
// phase_shift_checker
//
// Simulation-side checker for PLL verification. While the PLL reports lock,
// it measures the delay from each clk rising edge to the next clk_shifted
// rising edge and compares it with the delay implied by the requested phase
// shift. Any mismatch larger than TOLERANCE_PS raises a sticky fail flag.
//
// Time is taken from simulation time in ps, so this block is intended for
// simulation only, alongside the clock-output models.
//
// Parameters:
//   TOLERANCE_PS        maximum allowed absolute delay error in ps
//
// Ports:
//   clk                 reference clock; all state updates on its rising edge
//   rst                 synchronous, active-high reset
//   desired_shift_1000  requested shift in degrees x 1000 (signed)
//   clk_period_1000     clk period in ps
//   clk_shifted         observed phase-shifted clock
//   LOCKED              PLL lock indication; checking only while high
//   fail                sticky mismatch flag
//
// Configuration macro:
//   PHASE_SHIFT_CHECK_MSG_EN  when defined, each mismatch prints one line
//                             with the time, measured and expected delay.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module phase_shift_checker #(
    parameter int TOLERANCE_PS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] desired_shift_1000,
    input  logic [31:0] clk_period_1000,
    input  logic        clk_shifted,
    input  logic        LOCKED,
    output logic        fail
);

    localparam longint FULL_TURN = 64'sd360000;

    // Declaration initialisers give the power-up values before the first reset.
    logic       fail_r         = 1'b0;
    logic       ref_valid      = 1'b0;
    longint     t_ref          = 64'sd0;
    logic [7:0] mismatch_count = 8'd0;
    logic [7:0] seen_count     = 8'd0;

    longint period_ps;
    longint exp_ps;

    // Current simulation time in ps, rounded to the nearest ps.
    function automatic longint now_ps();
        return longint'($realtime * 1000.0);
    endfunction

    // Normalise the requested shift into [0, 360000) and scale by the period.
    function automatic longint expected_delay(input logic [31:0] shift,
                                              input longint      period);
        longint s;
        s = longint'($signed(shift)) % FULL_TURN;
        if (s < 64'sd0) begin
            s = s + FULL_TURN;
        end
        return (s * period) / FULL_TURN;
    endfunction

    // Delay from the last reference edge, folded into one period.
    function automatic longint measured_delay(input longint now,
                                              input longint tref,
                                              input longint period);
        return (now - tref) % period;
    endfunction

    // Circular distance: a delay of 0 and of a full period are equivalent.
    function automatic longint circular_error(input longint d,
                                              input longint e,
                                              input longint period);
        longint diff;
        longint alt;
        diff = d - e;
        if (diff < 64'sd0) begin
            diff = -diff;
        end
        alt = period - diff;
        return (alt < diff) ? alt : diff;
    endfunction

    assign period_ps = longint'(clk_period_1000);

    always_comb begin
        exp_ps = expected_delay(desired_shift_1000, period_ps);
    end

    // Measurement side. Mismatches are handed to the clk side by bumping a
    // counter, so each variable keeps a single driver; a pending mismatch is
    // simply "counter differs from what the clk side has already seen".
    // Because t_ref is updated with a non-blocking assignment, a clk_shifted
    // edge coinciding with a clk edge is measured against the previous t_ref.
    always_ff @(posedge clk_shifted) begin
        if (LOCKED && !rst && ref_valid && period_ps != 64'sd0) begin
            if (circular_error(measured_delay(now_ps(), t_ref, period_ps),
                               exp_ps, period_ps) > longint'(TOLERANCE_PS)) begin
                mismatch_count <= mismatch_count + 8'd1;
`ifdef PHASE_SHIFT_CHECK_MSG_EN
                $display("phase_shift_checker: mismatch at %0t, measured %0d ps, expected %0d ps",
                         $realtime, measured_delay(now_ps(), t_ref, period_ps), exp_ps);
`endif
            end
        end
    end

    // Reference side: records t_ref while locked, promotes a pending
    // mismatch into the sticky fail flag, and lets reset win over a pending
    // mismatch by acknowledging it without setting fail.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_r     <= 1'b0;
            ref_valid  <= 1'b0;
            seen_count <= mismatch_count;
        end else begin
            if (mismatch_count != seen_count) begin
                fail_r     <= 1'b1;
                seen_count <= mismatch_count;
            end
            if (LOCKED) begin
                t_ref     <= now_ps();
                ref_valid <= 1'b1;
            end else begin
                ref_valid <= 1'b0;
            end
        end
    end

    assign fail = fail_r;

endmodule

// File: tb/tb_phase_shift_checker.sv
//----------------------------------------------------------------------------
// tb_phase_shift_checker
//
// Directed bench for phase_shift_checker: a 20 ns reference clock, a shifted
// clock model whose delay is set per step, a table of stimulus steps with
// expected fail values, and hand-written sequences for detection latency and
// reset priority over a pending mismatch.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_phase_shift_checker;

    typedef struct {
        string name;
        logic  rst;
        logic  locked;
        int    desired;
        int    period;
        real   shift_ns;
        int    cycles;
        logic  exp_fail;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] desired_shift_1000 = 32'd45000;
    logic [31:0] clk_period_1000 = 32'd20000;
    logic        clk_shifted = 1'b0;
    logic        LOCKED = 1'b0;
    logic        fail;

    real shift_ns = 2.5;
    int  checks = 0;
    int  failures = 0;

    vec_t vecs[16];

    phase_shift_checker #(.TOLERANCE_PS(1)) dut (
        .clk                (clk),
        .rst                (rst),
        .desired_shift_1000 (desired_shift_1000),
        .clk_period_1000    (clk_period_1000),
        .clk_shifted        (clk_shifted),
        .LOCKED             (LOCKED),
        .fail               (fail)
    );

    // 20 ns reference clock.
    always #10 clk = ~clk;

    // Shifted clock model: each reference edge launches a 10 ns high pulse
    // delayed by the shift captured at that edge.
    always @(posedge clk) begin
        fork
            begin
                automatic real d = shift_ns;
                #(d) clk_shifted = 1'b1;
                #10 clk_shifted = 1'b0;
            end
        join_none
    end

    // Hard stop in case the bench ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time expired, required finish before 1 ms");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input string name, input logic r, input logic lk,
                                input int des, input int per, input real sh,
                                input int cyc, input logic ef);
        vec_t v;
        v.name = name; v.rst = r; v.locked = lk; v.desired = des;
        v.period = per; v.shift_ns = sh; v.cycles = cyc; v.exp_fail = ef;
        return v;
    endfunction

    // Inputs change 18 ns after a rising edge, after every in-flight shifted
    // edge of the current cycle, so each step is measured against one setting.
    task automatic applyStimulus(input vec_t v);
        rst                = v.rst;
        LOCKED             = v.locked;
        desired_shift_1000 = v.desired;
        clk_period_1000    = v.period;
        shift_ns           = v.shift_ns;
        repeat (v.cycles) @(posedge clk);
        #18;
    endtask

    task automatic checkOutput(input string name, input logic exp);
        checks++;
        if (fail !== exp) begin
            failures++;
            $display("[TB] FAIL %s: fail=%b required %b at %0t", name, fail, exp, $realtime);
        end
    endtask

    initial begin
        vecs[0]  = mk("reset",              1, 0,   45000, 20000, 2.5,   1,  0);
        vecs[1]  = mk("unlocked_wrong",     0, 0,   45000, 20000, 5.0,   2,  0);
        vecs[2]  = mk("locked_match",       0, 1,   45000, 20000, 2.5,   50, 0);
        vecs[3]  = mk("mismatch_90",        0, 1,   45000, 20000, 5.0,   50, 1);
        vecs[4]  = mk("sticky_match",       0, 1,   45000, 20000, 2.5,   10, 1);
        vecs[5]  = mk("sticky_unlocked",    0, 0,   45000, 20000, 5.0,   5,  1);
        vecs[6]  = mk("reset_mid_op",       1, 1,   45000, 20000, 2.5,   1,  0);
        vecs[7]  = mk("after_reset_match",  0, 1,   45000, 20000, 2.5,   20, 0);
        vecs[8]  = mk("neg_wrap",           0, 1, -315000, 20000, 2.5,   20, 0);
        vecs[9]  = mk("zero_shift",         0, 1,       0, 20000, 0.0,   20, 0);
        vecs[10] = mk("shift_270",          0, 1,  270000, 20000, 15.0,  20, 0);
        vecs[11] = mk("tol_edge_pass",      0, 1,   90000, 20000, 5.001, 20, 0);
        vecs[12] = mk("tol_edge_fail",      0, 1,   90000, 20000, 5.002, 20, 1);
        vecs[13] = mk("reset_again",        1, 1,   45000, 20000, 2.5,   1,  0);
        vecs[14] = mk("over_360",           0, 1,  405000, 20000, 2.5,   20, 0);
        vecs[15] = mk("period_change",      0, 1,   45000, 40000, 2.5,   20, 1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].exp_fail);
        end

        // Detection latency: the mismatching edge 5 ns after E1 must set
        // fail exactly at E2, not earlier.
        applyStimulus(mk("lat_reset", 1, 1, 45000, 20000, 2.5, 1, 0));
        checkOutput("lat_reset", 1'b0);
        rst      = 1'b0;
        shift_ns = 5.0;
        @(posedge clk); #1;
        checkOutput("lat_before_edge", 1'b0);
        @(posedge clk); #1;
        checkOutput("lat_at_next_edge", 1'b1);
        #17;

        // Reset priority: a mismatch is pending when rst is sampled, and it
        // must never reach fail afterwards.
        applyStimulus(mk("prio_reset", 1, 1, 45000, 20000, 2.5, 1, 0));
        checkOutput("prio_reset", 1'b0);
        applyStimulus(mk("prio_match", 0, 1, 45000, 20000, 2.5, 3, 0));
        checkOutput("prio_match", 1'b0);
        shift_ns = 5.0;
        @(posedge clk); #18;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("prio_reset_edge", 1'b0);
        #17;
        rst      = 1'b0;
        shift_ns = 2.5;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("prio_pending_dropped", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
